// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Packs an incoming byte stream into 32-bit little-endian instruction words and
// writes them into instruction memory through the datapath ADDRESS/INSTRUCTION
// load path. When the image is complete and consistent it raises start, which
// releases the fetch stage. start stays low while loading and after an error.
//
// Optional feature (macro LOADER_CSUM_EN):
//   When defined, adds exp_csum/csum. csum XOR-accumulates every written word.
//   The final word only reaches DONE if the accumulated checksum matches
//   exp_csum. When undefined the final write always reaches DONE.
//
// Parameters:
//   MAX_WORDS  instruction memory capacity in words
//   BASE_ADDR  byte address of the first loaded word (4-byte aligned)
//   CNT_W      width of word_count
//
// Ports:
//   clk          rising-edge clock shared with the datapath
//   rst          synchronous active-high reset
//   load_req     single-cycle pulse that begins a new load
//   in_valid     in_data carries a valid byte
//   in_data      stream byte
//   in_last      final byte of the image (qualified by in_valid)
//   in_ready     loader accepts a byte this cycle
//   instr_we     instruction-memory write strobe
//   ADDRESS      byte write address
//   INSTRUCTION  write data
//   start        program loaded, core may run
//   busy         load in progress
//   error        load aborted (partial word, overflow, checksum mismatch)
//   word_count   words written in the current or last load
//   exp_csum     expected checksum          (LOADER_CSUM_EN only)
//   csum         running checksum           (LOADER_CSUM_EN only)
//
// All outputs come straight from registers; next values are derived from the
// next state so that e.g. in_ready rises the cycle after load_req.
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int          MAX_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             instr_we,
    output logic [31:0]      ADDRESS,
    output logic [31:0]      INSTRUCTION,
    output logic             start,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] word_count
`ifdef LOADER_CSUM_EN
    ,
    input  logic [31:0]      exp_csum,
    output logic [31:0]      csum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WORD_IDX = CNT_W'(MAX_WORDS - 1);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       buf_q, buf_d;
    logic              last_word_q, last_word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       instr_q, instr_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic              accept_s;
    logic              final_ok_s;
    logic [31:0]       cnt_ext_s;
`ifdef LOADER_CSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    assign accept_s  = in_valid & in_ready_q;
    assign cnt_ext_s = 32'(cnt_q);

    // Decide whether the final word may complete the load.
    always_comb begin
        final_ok_s = 1'b1;
`ifdef LOADER_CSUM_EN
        // csum_q does not yet include the word being written this cycle.
        if ((csum_q ^ instr_q) == exp_csum) begin
            final_ok_s = 1'b1;
        end else begin
            final_ok_s = 1'b0;
        end
`endif
    end

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        last_word_d = last_word_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
`ifdef LOADER_CSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_req) begin
                    state_d     = S_RECV;
                    idx_d       = 2'd0;
                    buf_d       = 32'h0000_0000;
                    last_word_d = 1'b0;
                    cnt_d       = '0;
`ifdef LOADER_CSUM_EN
                    csum_d      = 32'h0000_0000;
`endif
                end else begin
                    state_d = state_q;
                end
            end

            S_RECV: begin
                if (accept_s) begin
                    if (idx_q == 2'd3) begin
                        buf_d[31:24] = in_data;
                        instr_d      = buf_d;
                        addr_d       = BASE_ADDR + (cnt_ext_s << 2);
                        last_word_d  = in_last;
                        state_d      = S_WRITE;
                    end else if (in_last) begin
                        // Image ended mid-word: drop the byte and abort.
                        state_d = S_ERR;
                    end else begin
                        buf_d[{idx_q, 3'b000} +: 8] = in_data;
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    state_d = S_RECV;
                end
            end

            S_WRITE: begin
                cnt_d = cnt_q + CNT_W'(1);
                idx_d = 2'd0;
`ifdef LOADER_CSUM_EN
                csum_d = csum_q ^ instr_q;
`endif
                if (last_word_q) begin
                    if (final_ok_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (cnt_q == LAST_WORD_IDX) begin
                    // Memory full but more data pending: this word is still
                    // written, the rest of the image is rejected.
                    state_d = S_ERR;
                end else begin
                    state_d = S_RECV;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_RECV);
        we_d       = (state_d == S_WRITE);
        busy_d     = (state_d == S_RECV) || (state_d == S_WRITE);
        start_d    = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            buf_q       <= 32'h0000_0000;
            last_word_q <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= BASE_ADDR;
            instr_q     <= 32'h0000_0000;
            in_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef LOADER_CSUM_EN
            csum_q      <= 32'h0000_0000;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            last_word_q <= last_word_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            in_ready_q  <= in_ready_d;
            we_q        <= we_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
`ifdef LOADER_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign instr_we    = we_q;
    assign ADDRESS     = addr_q;
    assign INSTRUCTION = instr_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign error       = error_q;
    assign word_count  = cnt_q;
`ifdef LOADER_CSUM_EN
    assign csum        = csum_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Drives byte images into program_loader (MAX_WORDS=4) and compares the
// observed memory writes and final status against a reference computed from
// the image itself: complete words, little-endian packing, capacity limit and
// (with LOADER_CSUM_EN) the XOR checksum.
// -----------------------------------------------------------------------------
module tb_program_loader;

    localparam int          MW   = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          CW   = $clog2(MW + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          load_req;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic          instr_we;
    logic [31:0]   ADDRESS;
    logic [31:0]   INSTRUCTION;
    logic          start;
    logic          busy;
    logic          error;
    logic [CW-1:0] word_count;
    logic [31:0]   exp_csum_v;
`ifdef LOADER_CSUM_EN
    logic [31:0]   csum;
`endif

    program_loader #(.MAX_WORDS(MW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .load_req(load_req),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .instr_we(instr_we),
        .ADDRESS(ADDRESS), .INSTRUCTION(INSTRUCTION),
        .start(start), .busy(busy), .error(error), .word_count(word_count)
`ifdef LOADER_CSUM_EN
        , .exp_csum(exp_csum_v), .csum(csum)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  img [0:31];
    logic [31:0] wa_q [$];
    logic [31:0] wd_q [$];
    int          cyc = 0;
    int          last_we_cyc = -1;
    int          start_rise_cyc = -1;
    logic        start_prev = 1'b0;

    // Write monitor: records every memory write and when start rises.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (instr_we === 1'b1) begin
            wa_q.push_back(ADDRESS);
            wd_q.push_back(INSTRUCTION);
            last_we_cyc = cyc;
        end
        if (start === 1'b1 && start_prev !== 1'b1) start_rise_cyc = cyc;
        start_prev = start;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int k);
        return {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
    endfunction

    // XOR of all complete words of an image of nbytes bytes.
    function automatic logic [31:0] image_xor(input int nbytes);
        logic [31:0] x = 32'h0000_0000;
        for (int k = 0; k < nbytes / 4; k++) x = x ^ word_of(k);
        return x;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_instr_we"}, 32'(instr_we), 32'd0);
        chk({tag, "_ADDRESS"}, ADDRESS, BASE);
        chk({tag, "_INSTRUCTION"}, INSTRUCTION, 32'd0);
        chk({tag, "_start"}, 32'(start), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
`ifdef LOADER_CSUM_EN
        chk({tag, "_csum"}, csum, 32'd0);
`endif
    endtask

    // gap_mode: 0 continuous, 1 in_valid every other cycle, 2 random gaps.
    // inject_at: loop iteration at which a stray load_req is pulsed (-1: none).
    task automatic run_load(input string tag, input int last_pos, input int gap_mode,
                            input int inject_at);
        int i = 0;
        int budget = 0;
        bit toggle = 1'b0;
        bit gap;
        int nbytes, nw, exp_writes, n_cmp;
        bit exp_err;
        logic [31:0] xs;

        @(negedge clk);
        wa_q.delete(); wd_q.delete();
        last_we_cyc = -1; start_rise_cyc = -1;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk({tag, "_ready_after_req"}, 32'(in_ready), 32'd1);
        chk({tag, "_start_drop"}, 32'(start), 32'd0);

        while (i <= last_pos && budget < 2000) begin
            if (busy !== 1'b1) break;
            case (gap_mode)
                1:       gap = toggle;
                2:       gap = ($urandom_range(0, 2) == 0);
                default: gap = 1'b0;
            endcase
            toggle   = ~toggle;
            in_valid = ~gap;
            in_data  = img[i];
            in_last  = (i == last_pos);
            load_req = (budget == inject_at);
            if (!gap && in_ready === 1'b1) i++;
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0; in_last = 1'b0; load_req = 1'b0;
        chk({tag, "_stream_budget"}, 32'(budget < 2000), 32'd1);
        for (int k = 0; k < 20 && busy === 1'b1; k++) @(negedge clk);
        repeat (2) @(negedge clk);

        // Reference: complete words are written up to capacity; an odd tail,
        // an image larger than memory or a bad checksum ends in error.
        nbytes     = last_pos + 1;
        nw         = nbytes / 4;
        exp_writes = (nw < MW) ? nw : MW;
        exp_err    = (nbytes % 4 != 0) || (nw > MW);
        xs         = image_xor(4 * exp_writes);
`ifdef LOADER_CSUM_EN
        if (!exp_err && xs != exp_csum_v) exp_err = 1'b1;
        chk({tag, "_csum"}, csum, xs);
`endif
        chk({tag, "_n_writes"}, 32'(wa_q.size()), 32'(exp_writes));
        n_cmp = (wa_q.size() < exp_writes) ? wa_q.size() : exp_writes;
        for (int k = 0; k < n_cmp; k++) begin
            chk($sformatf("%s_addr%0d", tag, k), wa_q[k], BASE + 32'(4 * k));
            chk($sformatf("%s_data%0d", tag, k), wd_q[k], word_of(k));
        end
        chk({tag, "_start"}, 32'(start), 32'(!exp_err));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'(exp_writes));
        if (!exp_err) chk({tag, "_start_timing"}, 32'(start_rise_cyc), 32'(last_we_cyc + 1));
    endtask

    task automatic load_basic_image();
        img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
        img[4] = 8'h93; img[5] = 8'h00; img[6] = 8'h10; img[7] = 8'h00;
    endtask

    initial begin
        rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        exp_csum_v = 32'h0010_0080;
        for (int k = 0; k < 32; k++) img[k] = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Two-word image, continuous and with alternating gaps.
        load_basic_image();
        chk("img_word0", word_of(0), 32'h0000_0013);
        chk("img_word1", word_of(1), 32'h0010_0093);
        run_load("basic", 7, 0, -1);
        run_load("alt_valid", 7, 1, -1);

        // in_last on the 6th byte: one write then error, then clean reload.
        run_load("partial", 5, 0, -1);
        run_load("reload", 7, 0, -1);

        // Five words into a four-word memory.
        for (int k = 0; k < 20; k++) img[k] = 8'($urandom);
        exp_csum_v = image_xor(16);
        run_load("overflow", 19, 0, -1);

        // Exactly full memory is a legal image.
        run_load("full", 15, 2, -1);

        // Stray load_req mid-load is ignored.
        load_basic_image();
        exp_csum_v = 32'h0010_0080;
        run_load("stray_req", 7, 0, 2);

`ifdef LOADER_CSUM_EN
        exp_csum_v = 32'h0000_0000;
        run_load("csum_bad", 7, 0, -1);
        exp_csum_v = 32'h0010_0080;
`endif

        // Reset mid-RECV with a byte in flight.
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("mid_rst");
        rst = 1'b0; in_valid = 1'b0;

        // Randomised images.
        for (int r = 0; r < 12; r++) begin
            int nb;
            if ($urandom_range(0, 1) == 1) nb = 4 * $urandom_range(1, MW);
            else nb = $urandom_range(1, 4 * (MW + 1) + 2);
            for (int k = 0; k < 32; k++) img[k] = 8'($urandom);
            exp_csum_v = image_xor(nb);
            if ($urandom_range(0, 3) == 0) exp_csum_v = exp_csum_v ^ 32'h0000_0100;
            run_load($sformatf("rand%0d", r), nb - 1, $urandom_range(0, 2),
                     ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
